beep_melody_ctrl: RTL and testbench

//  Sequencer for the piezo buzzer tone divider. Plays a stored tune of
//  (half-period, duration) entries on key command: start, stop, repeat toggle.

---
 rtl/beep_melody_ctrl_pkg.sv | 50 +++++
 rtl/beep_melody_ctrl_if.sv | 10 +
 rtl/beep_melody_ctrl_tone_gen.sv | 34 +++
 rtl/beep_melody_ctrl.sv | 157 +++++++++++++++
 tb/tb_beep_melody_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/beep_melody_ctrl_pkg.sv
// Shared types for the buzzer melody sequencer: FSM encoding, tune entry layout
// and the two stored tunes.
package beep_melody_ctrl_pkg;

  localparam int HP_W  = 20;
  localparam int DUR_W = 8;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
  } entry_t;

  // hp = 0 is a rest, dur = 0 marks the end of the tune.
  function automatic entry_t tune_entry(input logic sel, input logic [IDX_W-1:0] idx);
    entry_t e;
    e = '{hp: '0, dur: '0};
    if (sel) begin
      case (idx)
        4'd0:    e = '{hp: 20'd5, dur: 8'd2};
        4'd1:    e = '{hp: 20'd0, dur: 8'd1};
        4'd2:    e = '{hp: 20'd3, dur: 8'd1};
        default: e = '{hp: '0, dur: '0};
      endcase
    end else begin
      // C major scale at 50 MHz: hp = 25e6 / f.
      case (idx)
        4'd0:    e = '{hp: 20'd95420, dur: 8'd4};
        4'd1:    e = '{hp: 20'd85034, dur: 8'd4};
        4'd2:    e = '{hp: 20'd75758, dur: 8'd4};
        4'd3:    e = '{hp: 20'd71633, dur: 8'd4};
        4'd4:    e = '{hp: 20'd63776, dur: 8'd4};
        4'd5:    e = '{hp: 20'd56818, dur: 8'd4};
        4'd6:    e = '{hp: 20'd50607, dur: 8'd4};
        4'd7:    e = '{hp: 20'd47801, dur: 8'd8};
        4'd8:    e = '{hp: 20'd0,     dur: 8'd4};
        default: e = '{hp: '0, dur: '0};
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/beep_melody_ctrl_if.sv
// Board-side signals of the melody sequencer: keys in, buzzer and LEDs out.
interface beep_melody_ctrl_if;
  logic [4:0] key;
  logic       beep;
  logic [4:0] led;
  logic       busy;

  modport master (output key, input beep, input led, input busy);
  modport slave  (input key, output beep, output led, output busy);
endinterface

// File: rtl/beep_melody_ctrl_tone_gen.sv
// Square-wave divider for the buzzer; the output is forced low whenever disabled.
module beep_melody_ctrl_tone_gen
  import beep_melody_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] hp,
  output logic            beep
);

  logic [HP_W-1:0] cnt_q;
  logic            beep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else if (!en || clr) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
    end else if (cnt_q == hp - HP_W'(1)) begin
      cnt_q  <= '0;
      beep_q <= ~beep_q;
    end else begin
      cnt_q  <= cnt_q + HP_W'(1);
    end
  end

  // Gating keeps the pin low in the very cycle the note ends.
  assign beep = beep_q & en;

endmodule

// File: rtl/beep_melody_ctrl.sv
// Key-driven tune sequencer: debounced start/stop/repeat commands step through
// the stored tune and drive the tone divider.
module beep_melody_ctrl
  import beep_melody_ctrl_pkg::*;
#(
  parameter int unsigned UNIT_CYC = 2_500_000,
  parameter int unsigned GAP_CYC  = 250_000,
  parameter int unsigned DEB_CYC  = 1_000_000,
  parameter int unsigned TUNE_SEL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  beep_melody_ctrl_if.slave   bus
);

  localparam logic [31:0]      UNIT_C  = 32'(UNIT_CYC);
  localparam logic [31:0]      GAP_C   = 32'(GAP_CYC);
  localparam logic [31:0]      DEB_C   = 32'(DEB_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  logic [2:0]       key_p0, key_p1, key_p2;
  logic [2:0]       fall;
  logic [2:0]       cmd_q;
  logic [31:0]      lock_q;
  logic             rep_q;
  logic             unused_key;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      timer_q, timer_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  entry_t           ent;
  logic             tone_en, tone_clr, busy;

  assign unused_key = ^bus.key[4:3];
  assign fall       = key_p2 & ~key_p1;

  // Key sync (p0, p1), edge history (p2), then a registered command pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= '0;
      key_p1 <= '0;
      key_p2 <= '0;
      cmd_q  <= '0;
      lock_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      key_p0 <= bus.key[2:0];
      key_p1 <= key_p0;
      key_p2 <= key_p1;
      cmd_q  <= '0;
      if (lock_q != '0) begin
        lock_q <= lock_q - 32'd1;
      end else if (fall != '0) begin
        lock_q <= DEB_C;
        cmd_q  <= fall;
      end
      if (cmd_q[2]) rep_q <= ~rep_q;
    end
  end

  assign ent = tune_entry(TUNE_SEL != 0, idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      hp_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      hp_q    <= hp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    hp_d    = hp_q;
    if (cmd_q[1]) begin
      state_d = S_IDLE;
    end else if (cmd_q[0]) begin
      state_d = S_LOAD;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (ent.dur == '0) begin
            idx_d   = rep_q ? '0 : idx_q;
            state_d = rep_q ? S_LOAD : S_IDLE;
          end else begin
            hp_d    = ent.hp;
            timer_d = 32'(ent.dur) * UNIT_C;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (timer_q <= 32'd1) begin
            timer_d = GAP_C;
            state_d = S_GAP;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        S_GAP: begin
          if (timer_q <= 32'd1) begin
            // Running off the last slot behaves like an end marker.
            if (idx_q == IDX_MAX) begin
              idx_d   = '0;
              state_d = rep_q ? S_LOAD : S_IDLE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_LOAD;
            end
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tone_en  = 1'b0;
    tone_clr = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LOAD: begin
        tone_clr = 1'b1;
        busy     = 1'b1;
      end
      S_PLAY: begin
        tone_en = (hp_q != '0);
        busy    = 1'b1;
      end
      S_GAP:   busy = 1'b1;
      default: ;
    endcase
  end

  beep_melody_ctrl_tone_gen u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tone_en),
    .clr   (tone_clr),
    .hp    (hp_q),
    .beep  (bus.beep)
  );

  assign bus.busy = busy;
  assign bus.led  = {rep_q, idx_q};

endmodule

// File: tb/tb_beep_melody_ctrl.sv
// Scoreboard bench for the melody sequencer running the short test tune.
module tb_beep_melody_ctrl;

  typedef logic [6:0] obs_t;  // {beep, busy, led[4:0]}

  localparam int UNIT = 4;
  localparam int GAP  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;
  obs_t tr[$];
  obs_t exp_q[$];
  int   tune_hp[4]  = '{5, 0, 3, 0};
  int   tune_dur[4] = '{2, 1, 1, 0};

  beep_melody_ctrl_if ifc ();

  beep_melody_ctrl #(
    .UNIT_CYC (4),
    .GAP_CYC  (2),
    .DEB_CYC  (3),
    .TUNE_SEL (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  function automatic obs_t observe();
    return {ifc.beep, ifc.busy, ifc.led};
  endfunction

  // Expected per-cycle outputs from the first LOAD cycle onward.
  task automatic gen_trace(input bit rep, input int n);
    int idx;
    bit b;
    idx = 0;
    tr.delete();
    while (tr.size() < n) begin
      tr.push_back({1'b0, 1'b1, rep, idx[3:0]});
      if (tune_dur[idx] == 0) begin
        if (rep) begin
          idx = 0;
          continue;
        end
        break;
      end
      for (int k = 1; k <= tune_dur[idx] * UNIT; k++) begin
        b = 1'b0;
        if (tune_hp[idx] != 0) b = (((k - 1) / tune_hp[idx]) % 2) == 1;
        tr.push_back({b, 1'b1, rep, idx[3:0]});
      end
      for (int g = 0; g < GAP; g++) tr.push_back({1'b0, 1'b1, rep, idx[3:0]});
      idx++;
    end
    while (tr.size() < n) tr.push_back({1'b0, 1'b0, rep, idx[3:0]});
  endtask

  // Leaves the bench one tick before the LOAD cycle.
  task automatic press_start();
    ifc.key = 5'b11110;
    tick();
    ifc.key = 5'b11111;
    tick();
    tick();
  endtask

  task automatic test_reset();
    obs_t got;
    ifc.key = 5'b11111;
    rst_n   = 1'b0;
    idle(3);
    got = observe();
    total++;
    if (got !== 7'b0) $display("FAIL reset_hold got %b want %b", got, 7'b0);
    else passed++;
    rst_n = 1'b1;
    idle(2);
    got = observe();
    total++;
    if (got !== 7'b0) $display("FAIL reset_release got %b want %b", got, 7'b0);
    else passed++;
  endtask

  task automatic test_play();
    obs_t got, e;
    int i;
    gen_trace(1'b0, 30);
    exp_q.delete();
    foreach (tr[j]) exp_q.push_back(tr[j]);
    press_start();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      got = observe();
      total++;
      if (got !== e) $display("FAIL play[%0d] got %b want %b", i, got, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_stop();
    obs_t got, e;
    int i;
    gen_trace(1'b0, 30);
    exp_q.delete();
    for (int j = 0; j <= 20; j++) exp_q.push_back(tr[j]);
    for (int j = 0; j < 6; j++) exp_q.push_back({2'b00, tr[20][4:0]});
    press_start();
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == 18) ifc.key = 5'b11101;
      else if (i == 19) ifc.key = 5'b11111;
      e = exp_q.pop_front();
      tick();
      got = observe();
      total++;
      if (got !== e) $display("FAIL stop[%0d] got %b want %b", i, got, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_start_stop_same();
    obs_t got, e;
    int i;
    gen_trace(1'b0, 30);
    exp_q.delete();
    for (int j = 0; j <= 7; j++) exp_q.push_back(tr[j]);
    for (int j = 0; j < 6; j++) exp_q.push_back({2'b00, tr[7][4:0]});
    press_start();
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == 5) ifc.key = 5'b11100;
      else if (i == 6) ifc.key = 5'b11111;
      e = exp_q.pop_front();
      tick();
      got = observe();
      total++;
      if (got !== e) $display("FAIL start_stop[%0d] got %b want %b", i, got, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_debounce_restart();
    obs_t got, e;
    int i;
    gen_trace(1'b0, 30);
    exp_q.delete();
    for (int j = 0; j <= 22; j++) exp_q.push_back(tr[j]);
    foreach (tr[j]) exp_q.push_back(tr[j]);
    // Second falling edge lands inside the lockout window.
    ifc.key = 5'b11110;
    tick();
    ifc.key = 5'b11111;
    tick();
    ifc.key = 5'b11110;
    tick();
    ifc.key = 5'b11111;
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == 20) ifc.key = 5'b11110;
      else if (i == 21) ifc.key = 5'b11111;
      e = exp_q.pop_front();
      tick();
      got = observe();
      total++;
      if (got !== e) $display("FAIL debounce_restart[%0d] got %b want %b", i, got, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_repeat();
    obs_t got, e;
    int i;
    ifc.key = 5'b11011;
    tick();
    ifc.key = 5'b11111;
    idle(6);
    got = observe();
    total++;
    if (got !== 7'b0010011) $display("FAIL repeat_flag got %b want %b", got, 7'b0010011);
    else passed++;
    gen_trace(1'b1, 40);
    exp_q.delete();
    for (int j = 0; j <= 32; j++) exp_q.push_back(tr[j]);
    for (int j = 0; j < 6; j++) exp_q.push_back({2'b00, tr[32][4:0]});
    press_start();
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == 30) ifc.key = 5'b11101;
      else if (i == 31) ifc.key = 5'b11111;
      e = exp_q.pop_front();
      tick();
      got = observe();
      total++;
      if (got !== e) $display("FAIL repeat[%0d] got %b want %b", i, got, e);
      else passed++;
      i++;
    end
  endtask

  task automatic test_async_reset();
    obs_t got, e;
    int i;
    gen_trace(1'b1, 23);
    exp_q.delete();
    for (int j = 0; j <= 22; j++) exp_q.push_back(tr[j]);
    press_start();
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      got = observe();
      total++;
      if (got !== e) $display("FAIL pre_async[%0d] got %b want %b", i, got, e);
      else passed++;
      i++;
    end
    rst_n = 1'b0;
    #1;
    got = observe();
    total++;
    if (got !== 7'b0) $display("FAIL async_reset got %b want %b", got, 7'b0);
    else passed++;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    got = observe();
    total++;
    if (got !== 7'b0) $display("FAIL post_reset got %b want %b", got, 7'b0);
    else passed++;
  endtask

  initial begin
    ifc.key = 5'b11111;
    test_reset();
    test_play();
    idle(6);
    test_stop();
    idle(6);
    test_start_stop_same();
    idle(6);
    test_debounce_restart();
    idle(6);
    test_repeat();
    idle(6);
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
